map_tile_server: RTL and testbench

Tile-map store and responder for the game map. Holds one 2-bit tile code per cell of the NUM_ROW × NUM_COL logic map and serves 1-cycle synchronous reads to the obstacle checker. After every reset it builds the starting layout itself: border and pillar walls, plus bricks from an LFSR. It also accepts tile update commands (bomb placement, explosion clears) from game logic through a valid/ready port.

---
 rtl/map_tile_server.sv | 269 ++++++++++++++++++++++++++
 tb/tb_map_tile_server.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_tile_server.sv
`default_nettype none
// ============================================================================
// Module      : map_tile_server
// Description : Tile-map store and responder for the game map. Holds one
//               2-bit tile code per cell (00 empty, 01 hard wall, 10 brick,
//               11 bomb), builds the starting layout after every reset and
//               applies tile update commands from game logic.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset (restarts the layout build)
//   rd_addr        read address, row*NUM_COL+col
//   rd_data        tile at rd_addr of the previous cycle (01 while building
//                  or when the address is out of range)
//   wr_valid       command valid
//   wr_ready       command accepted when wr_valid && wr_ready
//   wr_op          00 WRITE, 01 CLEAR_BRICK, 10 CLEAR_BOMB, 11 NOP
//   wr_addr        target tile
//   wr_data        tile code for WRITE
//   init_done      layout build complete
//   brick_cleared  one-cycle pulse when CLEAR_BRICK destroys a brick
//   cleared_addr   address of the last destroyed brick
// Configuration
//   MAP_BRICKS_EN  when defined, non-wall cells are seeded with bricks from an
//                  8-bit LFSR; when undefined, the LFSR is omitted, every
//                  non-wall cell starts empty and CLEAR_BRICK never matches.
// ============================================================================
module map_tile_server #(
  parameter int          NUM_ROW    = 11,
  parameter int          NUM_COL    = 19,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  localparam int         DEPTH      = NUM_ROW * NUM_COL,
  localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]            rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [1:0]            wr_op,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            wr_data,
  output logic                  init_done,
  output logic                  brick_cleared,
  output logic [ADDR_WIDTH-1:0] cleared_addr
);

  localparam int ROW_W = $clog2(NUM_ROW);
  localparam int COL_W = $clog2(NUM_COL);

  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(NUM_ROW - 1);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(NUM_COL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] TILE_EMPTY = 2'b00;
  localparam logic [1:0] TILE_WALL  = 2'b01;
  localparam logic [1:0] TILE_BOMB  = 2'b11;

  localparam logic [1:0] OP_WRITE     = 2'b00;
  localparam logic [1:0] OP_CLR_BRICK = 2'b01;
  localparam logic [1:0] OP_CLR_BOMB  = 2'b10;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  // A zero seed would lock the LFSR at zero.
  if (LFSR_SEED == 8'h00) begin : g_seed_check
    $error("map_tile_server: LFSR_SEED must be nonzero");
  end

  logic [1:0]            state;
  logic [1:0]            state_nxt;

  logic [1:0]            mem [DEPTH];

  logic [ADDR_WIDTH-1:0] init_addr;
  logic [ROW_W-1:0]      init_row;
  logic [COL_W-1:0]      init_col;
  logic [1:0]            init_tile;

  logic [1:0]            chk_op;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [1:0]            chk_rdata;

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  clr_start;
  logic                  brick_hit;
  logic                  bomb_hit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [1:0]            mem_wdata;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;

  // Out-of-range clears are accepted in IDLE and simply dropped.
  assign clr_start = (state == S_IDLE) && wr_valid && wr_in_range &&
                     ((wr_op == OP_CLR_BRICK) || (wr_op == OP_CLR_BOMB));

  assign bomb_hit = (state == S_CHECK) && (chk_op == OP_CLR_BOMB) &&
                    (chk_rdata == TILE_BOMB);

  // --------------------------------------------------------------------------
  // Initial layout generator
  // --------------------------------------------------------------------------
  logic init_wall;
  assign init_wall = (init_row == '0) || (init_row == ROW_LAST) ||
                     (init_col == '0) || (init_col == COL_LAST) ||
                     (!init_row[0] && !init_col[0]);

`ifdef MAP_BRICKS_EN
  localparam logic [1:0] TILE_BRICK = 2'b10;

  logic [7:0] lfsr;
  logic       init_safe;

  // Spawn corners stay open so players are never boxed in by bricks.
  assign init_safe =
      ((init_row == ROW_W'(1)) && (init_col == COL_W'(1))) ||
      ((init_row == ROW_W'(1)) && (init_col == COL_W'(2))) ||
      ((init_row == ROW_W'(2)) && (init_col == COL_W'(1))) ||
      ((init_row == ROW_W'(NUM_ROW - 2)) && (init_col == COL_W'(NUM_COL - 2))) ||
      ((init_row == ROW_W'(NUM_ROW - 2)) && (init_col == COL_W'(NUM_COL - 3))) ||
      ((init_row == ROW_W'(NUM_ROW - 3)) && (init_col == COL_W'(NUM_COL - 2)));

  assign init_tile = init_wall                        ? TILE_WALL  :
                     init_safe                        ? TILE_EMPTY :
                     (lfsr[1:0] != 2'b00)             ? TILE_BRICK : TILE_EMPTY;

  assign brick_hit = (state == S_CHECK) && (chk_op == OP_CLR_BRICK) &&
                     (chk_rdata == TILE_BRICK);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepped once per build cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (state == S_INIT) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  assign init_tile = init_wall ? TILE_WALL : TILE_EMPTY;
  assign brick_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_addr == ADDR_LAST) state_nxt = S_IDLE;
      S_IDLE:  if (clr_start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and port-B write control
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = init_tile;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
      end
      S_IDLE: begin
        wr_ready = 1'b1;
        // NOP and out-of-range commands fall through with no write.
        if (wr_valid && (wr_op == OP_WRITE) && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
      S_CHECK: begin
        if (brick_hit || bomb_hit) begin
          mem_we    = 1'b1;
          mem_waddr = chk_addr;
          mem_wdata = TILE_EMPTY;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Tile storage: port B write (no reset, the build rewrites every entry)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers: build counters, clear pipeline, read port A
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      init_addr     <= '0;
      init_row      <= '0;
      init_col      <= '0;
      init_done     <= 1'b0;
      chk_op        <= OP_WRITE;
      chk_addr      <= '0;
      chk_rdata     <= TILE_EMPTY;
      brick_cleared <= 1'b0;
      cleared_addr  <= '0;
      rd_data       <= TILE_WALL;
    end else begin
      if (state == S_INIT) begin
        init_addr <= init_addr + 1'b1;
        // Row/col track the linear address without a divider.
        if (init_col == COL_LAST) begin
          init_col <= '0;
          init_row <= init_row + 1'b1;
        end else begin
          init_col <= init_col + 1'b1;
        end
        if (init_addr == ADDR_LAST) begin
          init_done <= 1'b1;
        end
      end

      // Port-B read of the target tile, consumed in CHECK.
      if (clr_start) begin
        chk_op    <= wr_op;
        chk_addr  <= wr_addr;
        chk_rdata <= mem[wr_addr];
      end

      brick_cleared <= brick_hit;
      if (brick_hit) begin
        cleared_addr <= chk_addr;
      end

      // Port A is read-first: a same-cycle port-B write shows up next read.
      if (init_done && rd_in_range) begin
        rd_data <= mem[rd_addr];
      end else begin
        rd_data <= TILE_WALL;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_tile_server.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_map_tile_server
// Description : Scoreboard bench for map_tile_server. Stimulus pushes the
//               expected read data / brick pulses into queues; a monitor
//               pops and compares whenever the DUT presents them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_map_tile_server;

  localparam int NR    = 11;
  localparam int NC    = 19;
  localparam int DEPTH = NR * NC;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    rd_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_op = 2'b11;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_data = 2'b00;
  logic          init_done;
  logic          brick_cleared;
  logic [AW-1:0] cleared_addr;

  map_tile_server dut (
    .clk           (clk),
    .rst           (rst),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_op         (wr_op),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .init_done     (init_done),
    .brick_cleared (brick_cleared),
    .cleared_addr  (cleared_addr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] model [DEPTH];

  logic [1:0] exp_q   [$];
  int         addr_q  [$];
  string      tag_q   [$];
  int         pulse_q [$];
  logic       rd_pend = 1'b0;
  logic       pend_s;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference layout built straight from the row/col rules and the LFSR.
  task automatic build_model();
    logic [7:0] l;
    bit wall, safe;
    l = 8'hA5;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        wall = (r == 0) || (r == NR-1) || (c == 0) || (c == NC-1) ||
               ((r % 2 == 0) && (c % 2 == 0));
        safe = (r == 1 && c == 1) || (r == 1 && c == 2) || (r == 2 && c == 1) ||
               (r == NR-2 && c == NC-2) || (r == NR-2 && c == NC-3) ||
               (r == NR-3 && c == NC-2);
        if (wall) model[r*NC+c] = 2'b01;
        else if (safe) model[r*NC+c] = 2'b00;
`ifdef MAP_BRICKS_EN
        else if (l[1:0] != 2'b00) model[r*NC+c] = 2'b10;
`endif
        else model[r*NC+c] = 2'b00;
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
    end
  endtask

  // Monitor: rd_data one edge after a read was presented, plus brick pulses.
  initial begin
    forever begin
      @(posedge clk);
      pend_s = rd_pend;
      #1;
      if (pend_s) begin
        if (exp_q.size() == 0) begin
          check("rd_underflow", 1, 0);
        end else begin
          logic [1:0] e;
          int a;
          string t;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          t = tag_q.pop_front();
          vectors++;
          if (rd_data !== e) begin
            miscompares++;
            $display("FAIL %s addr %0d: rd_data %0d, expected %0d", t, a, rd_data, e);
          end
        end
      end
      if (brick_cleared === 1'b1) begin
        if (pulse_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: cleared_addr %0d, expected no pulse", cleared_addr);
        end else begin
          check("pulse_addr", int'(cleared_addr), pulse_q.pop_front());
        end
      end
    end
  end

  task automatic rd(input int a, input logic [1:0] e, input string tag);
    @(negedge clk);
    rd_addr = a[AW-1:0];
    exp_q.push_back(e);
    addr_q.push_back(a);
    tag_q.push_back(tag);
    rd_pend = 1'b1;
    @(negedge clk);
    rd_pend = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_rd_data", int'(rd_data), 1);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_brick_cleared", int'(brick_cleared), 0);
    check("rst_cleared_addr", int'(cleared_addr), 0);
  endtask

  // Called right after rst falls at a negedge; counts edges up to init_done.
  task automatic release_and_build();
    int edges;
    rd(20, 2'b01, "rd_during_init");
    edges = 2;
    check("init_low_during_build", int'(init_done), 0);
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (init_done === 1'b1) break;
    end
    check("init_cycles", edges, DEPTH);
    check("ready_after_init", int'(wr_ready), 1);
  endtask

  task automatic clr(input logic [1:0] op, input int a, input bit pulse);
    if (pulse) pulse_q.push_back(a);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_addr  = a[AW-1:0];
    check("clr_ready_accept", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_op    = 2'b11;
    check("clr_ready_check", int'(wr_ready), 0);
    @(negedge clk);
    check("clr_ready_back", int'(wr_ready), 1);
    check("pulse_pending", pulse_q.size(), 0);
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < DEPTH; a++) rd(a, model[a], tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1, b2;
    build_model();
    b1 = 22;
    b2 = 22;
`ifdef MAP_BRICKS_EN
    b1 = -1;
    b2 = -1;
    for (int a = 60; a < DEPTH; a++) begin
      if (model[a] == 2'b10) begin
        if (b1 < 0) b1 = a;
        else if (b2 < 0) b2 = a;
      end
    end
    if (b1 < 0) b1 = 22;
    if (b2 < 0) b2 = 22;
`endif

    // Reset state and first build.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    release_and_build();

    rd(0,   2'b01, "rd_corner");
    rd(20,  2'b00, "rd_safe_1_1");
    rd(40,  2'b01, "rd_pillar_2_2");
    rd(188, 2'b00, "rd_safe_9_17");
    readback("build1");

    // WRITE with a same-cycle read of the same tile (read-first).
    @(negedge clk);
    wr_valid = 1'b1; wr_op = 2'b00; wr_addr = 8'd21; wr_data = 2'b11;
    rd_addr = 8'd21;
    exp_q.push_back(2'b00); addr_q.push_back(21); tag_q.push_back("rd_same_cycle_old");
    rd_pend = 1'b1;
    check("write_ready", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0; wr_op = 2'b11; rd_pend = 1'b0;
    check("ready_after_write", int'(wr_ready), 1);
    rd(21, 2'b11, "rd_after_write");

    // Back-to-back WRITEs.
    @(negedge clk);
    wr_valid = 1'b1; wr_op = 2'b00; wr_addr = 8'd23; wr_data = 2'b11;
    check("b2b_ready_0", int'(wr_ready), 1);
    @(negedge clk);
    wr_addr = 8'd24; wr_data = 2'b10;
    check("b2b_ready_1", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0; wr_op = 2'b11;
    rd(23, 2'b11, "rd_b2b_23");
    rd(24, 2'b10, "rd_b2b_24");

`ifdef MAP_BRICKS_EN
    // Destroy a real brick.
    clr(2'b01, b1, 1'b1);
    rd(b1, 2'b00, "rd_brick_cleared");
`else
    // No brick generation: a written 10 is not treated as a brick either.
    clr(2'b01, 24, 1'b0);
    rd(24, 2'b10, "rd_brick_disabled");
`endif
    clr(2'b01, 0, 1'b0);
    rd(0, 2'b01, "rd_wall_not_cleared");

    clr(2'b10, 21, 1'b0);
    rd(21, 2'b00, "rd_bomb_cleared_21");
    clr(2'b10, 23, 1'b0);
    rd(23, 2'b00, "rd_bomb_cleared_23");
    clr(2'b10, 20, 1'b0);
    rd(20, 2'b00, "rd_bomb_on_empty");
    clr(2'b10, 24, 1'b0);
    rd(24, 2'b10, "rd_bomb_on_brick");

    for (int a = DEPTH; a < 256; a++) rd(a, 2'b01, "rd_out_of_range");

    // Reset while a clear is in CHECK: no pulse, identical rebuild.
    @(negedge clk);
    wr_valid = 1'b1; wr_op = 2'b01; wr_addr = b2[AW-1:0];
    @(negedge clk);
    wr_valid = 1'b0; wr_op = 2'b11;
    check("ready_in_check", int'(wr_ready), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    release_and_build();
    readback("build2");

    repeat (4) @(negedge clk);
    check("pulse_leftover", pulse_q.size(), 0);
    check("rd_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
